// File: rtl/event_pkg.sv
// Shared constants and field layouts for the S2MM write-command path:
// command word, status word, error byte and the 24-bit completion word.
package event_pkg;

    localparam logic [18:0] START_OFFSET = 19'h03E00;
    localparam logic [18:0] BTT          = 19'd459008;
    localparam logic [22:0] CMD_BTT      = {4'b0000, BTT};

    localparam int IDX_W   = 13;
    localparam int TAG_W   = 4;
    localparam int ENTRY_W = IDX_W + TAG_W;

    localparam int CMD_W        = 72;
    localparam int CMD_TAG_LSB  = 64;
    localparam int CMD_ADDR_LSB = 32;
    localparam int CMD_DRR_BIT  = 31;
    localparam int CMD_EOF_BIT  = 30;
    localparam int CMD_DSA_LSB  = 24;
    localparam int CMD_TYPE_BIT = 23;
    localparam int CMD_BTT_LSB  = 0;

    localparam int CMPL_W       = 24;
    localparam int CMPL_IDX_LSB = 8;
    localparam int CMPL_IDX_W   = 13;

    localparam int STS_OKAY_BIT   = 7;
    localparam int STS_SLVERR_BIT = 6;
    localparam int STS_DECERR_BIT = 5;
    localparam int STS_INTERR_BIT = 4;
    localparam int STS_TAG_LSB    = 0;

    localparam int ERR_NOTOKAY_BIT = 7;
    localparam int ERR_SLVERR_BIT  = 6;
    localparam int ERR_DECERR_BIT  = 5;
    localparam int ERR_INTERR_BIT  = 4;
    localparam int ERR_TAGMIS_BIT  = 3;

    // Every event lands at the same offset of its own 512 KiB buffer.
    function automatic logic [CMD_W-1:0] build_cmd(input logic [IDX_W-1:0] index,
                                                   input logic [TAG_W-1:0] tag);
        logic [CMD_W-1:0] cmd;
        cmd                           = '0;
        cmd[CMD_TAG_LSB +: TAG_W]     = tag;
        cmd[CMD_ADDR_LSB +: 32]       = {index, START_OFFSET};
        cmd[CMD_DRR_BIT]              = 1'b0;
        cmd[CMD_EOF_BIT]              = 1'b1;
        cmd[CMD_DSA_LSB +: 6]         = 6'd0;
        cmd[CMD_TYPE_BIT]             = 1'b1;
        cmd[CMD_BTT_LSB +: 23]        = CMD_BTT;
        return cmd;
    endfunction

    function automatic logic [7:0] status_err(input logic [7:0] sts,
                                              input logic [TAG_W-1:0] tag);
        logic [7:0] err;
        err                  = 8'd0;
        err[ERR_NOTOKAY_BIT] = !sts[STS_OKAY_BIT];
        err[ERR_SLVERR_BIT]  = sts[STS_SLVERR_BIT];
        err[ERR_DECERR_BIT]  = sts[STS_DECERR_BIT];
        err[ERR_INTERR_BIT]  = sts[STS_INTERR_BIT];
        err[ERR_TAGMIS_BIT]  = (sts[STS_TAG_LSB +: TAG_W] != tag);
        return err;
    endfunction

endpackage

// File: rtl/event_writeback_cmd_gen_if.sv
// Stream bundle of the write-command generator: index requests in, S2MM commands out,
// S2MM status in, completions out. The master modport is the generator's view.
interface event_writeback_cmd_gen_if;
    import event_pkg::*;

    logic [IDX_W-1:0]  s_req_tdata;
    logic              s_req_tvalid;
    logic              s_req_tready;
    logic [CMD_W-1:0]  m_cmd_tdata;
    logic              m_cmd_tvalid;
    logic              m_cmd_tready;
    logic [7:0]        s_sts_tdata;
    logic              s_sts_tvalid;
    logic              s_sts_tready;
    logic [CMPL_W-1:0] m_cmpl_tdata;
    logic              m_cmpl_tvalid;
    logic              m_cmpl_tready;

    modport master (
        input  s_req_tdata, s_req_tvalid,
        output s_req_tready,
        output m_cmd_tdata, m_cmd_tvalid,
        input  m_cmd_tready,
        input  s_sts_tdata, s_sts_tvalid,
        output s_sts_tready,
        output m_cmpl_tdata, m_cmpl_tvalid,
        input  m_cmpl_tready
    );

    modport slave (
        output s_req_tdata, s_req_tvalid,
        input  s_req_tready,
        input  m_cmd_tdata, m_cmd_tvalid,
        output m_cmd_tready,
        output s_sts_tdata, s_sts_tvalid,
        input  s_sts_tready,
        input  m_cmpl_tdata, m_cmpl_tvalid,
        output m_cmpl_tready
    );
endinterface

// File: rtl/event_tag_fifo.sv
// In-order tracking FIFO of {index, tag} for commands issued but not yet completed.
// The occupancy count doubles as the outstanding-command counter.
module event_tag_fifo
    import event_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               memclk,
    input  logic               memrst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] pop_data,
    output logic               full,
    output logic               empty,
    output logic [4:0]         count
);
    localparam int             PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]  LAST = PW'(DEPTH - 1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full     = (count == 5'(DEPTH));
    assign empty    = (count == 5'd0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge memclk or posedge memrst) begin
        if (memrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 5'd0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + 5'd1;
            else if (do_pop && !do_push) count <= count - 5'd1;
        end
    end

    // Storage needs no reset: an empty FIFO is defined by the pointers alone.
    always_ff @(posedge memclk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/event_writeback_cmd_gen.sv
// S2MM write-command generator: buffer index -> DataMover command, S2MM status -> completion.
// Optional cmd/err counters are compiled in when EVENT_WRITEBACK_STATS_EN is defined.
module event_writeback_cmd_gen
    import event_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      memclk,
    input  logic                      memrst,
    event_writeback_cmd_gen_if.master bus,
    output logic [4:0]                outstanding_o,
    output logic                      any_err_o
`ifdef EVENT_WRITEBACK_STATS_EN
    ,
    output logic [31:0]               cmd_count_o,
    output logic [15:0]               err_count_o
`endif
);
    logic               fifo_full;
    logic               fifo_empty;
    logic [4:0]         fifo_count;
    logic [ENTRY_W-1:0] head;
    logic [IDX_W-1:0]   head_idx;
    logic [TAG_W-1:0]   head_tag;
    logic [TAG_W-1:0]   tag_cnt;
    logic               cmd_valid;
    logic [CMD_W-1:0]   cmd_data;
    logic               cmpl_valid;
    logic [CMPL_W-1:0]  cmpl_data;
    logic [CMPL_W-1:0]  cmpl_next;
    logic [7:0]         err_byte;
    logic               req_fire;
    logic               cmd_fire;
    logic               sts_fire;
    logic               sts_pop;
    logic               sts_spurious;
    logic               err_event;

    assign head_idx = head[ENTRY_W-1:TAG_W];
    assign head_tag = head[TAG_W-1:0];

    // One command register: a new request waits until the previous command is taken.
    assign bus.s_req_tready  = !memrst && !cmd_valid && !fifo_full;
    assign bus.s_sts_tready  = !memrst && (!cmpl_valid || bus.m_cmpl_tready);
    assign bus.m_cmd_tvalid  = cmd_valid;
    assign bus.m_cmd_tdata   = cmd_data;
    assign bus.m_cmpl_tvalid = cmpl_valid;
    assign bus.m_cmpl_tdata  = cmpl_data;

    assign req_fire     = bus.s_req_tvalid && bus.s_req_tready;
    assign cmd_fire     = cmd_valid && bus.m_cmd_tready;
    assign sts_fire     = bus.s_sts_tvalid && bus.s_sts_tready;
    assign sts_pop      = sts_fire && !fifo_empty;
    assign sts_spurious = sts_fire && fifo_empty;
    assign err_byte     = status_err(bus.s_sts_tdata, head_tag);
    assign err_event    = sts_spurious || (sts_pop && (err_byte != 8'd0));

    assign outstanding_o = fifo_count;

    event_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .memclk    (memclk),
        .memrst    (memrst),
        .push      (req_fire),
        .push_data ({bus.s_req_tdata, tag_cnt}),
        .pop       (sts_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        cmpl_next                                = '0;
        cmpl_next[CMPL_IDX_LSB +: CMPL_IDX_W]    = head_idx;
        cmpl_next[7:0]                           = err_byte;
    end

    always_ff @(posedge memclk or posedge memrst) begin
        if (memrst) begin
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
            tag_cnt   <= '0;
        end else if (req_fire) begin
            cmd_valid <= 1'b1;
            cmd_data  <= build_cmd(bus.s_req_tdata, tag_cnt);
            tag_cnt   <= tag_cnt + 4'd1;
        end else if (cmd_fire) begin
            cmd_valid <= 1'b0;
        end
    end

    // A status can only be accepted when the completion register is free or draining this cycle.
    always_ff @(posedge memclk or posedge memrst) begin
        if (memrst) begin
            cmpl_valid <= 1'b0;
            cmpl_data  <= '0;
            any_err_o  <= 1'b0;
        end else begin
            if (sts_pop) begin
                cmpl_valid <= 1'b1;
                cmpl_data  <= cmpl_next;
            end else if (bus.m_cmpl_tready) begin
                cmpl_valid <= 1'b0;
            end
            if (err_event) any_err_o <= 1'b1;
        end
    end

`ifdef EVENT_WRITEBACK_STATS_EN
    always_ff @(posedge memclk or posedge memrst) begin
        if (memrst) begin
            cmd_count_o <= 32'd0;
            err_count_o <= 16'd0;
        end else begin
            if (cmd_fire)  cmd_count_o <= cmd_count_o + 32'd1;
            if (err_event) err_count_o <= err_count_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_event_writeback_cmd_gen.sv
// Self-checking bench for event_writeback_cmd_gen: directed scenarios plus randomized
// traffic compared against a queue-based model of the command/completion rules.
module tb_event_writeback_cmd_gen;

    localparam int MAX_OUT = 4;

    logic       memclk;
    logic       memrst;
    logic [4:0] outstanding;
    logic       any_err;
`ifdef EVENT_WRITEBACK_STATS_EN
    logic [31:0] cmd_count;
    logic [15:0] err_count;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: commands in flight in issue order, pending output words.
    logic [16:0] mdl_flight[$];
    int          mdl_tag;
    bit          mdl_cmd_pend;
    logic [71:0] mdl_cmd;
    bit          mdl_cmpl_pend;
    logic [23:0] mdl_cmpl;
    bit          mdl_err;
    bit          last_req_acc;

    event_writeback_cmd_gen_if bus ();

    event_writeback_cmd_gen #(
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .memclk        (memclk),
        .memrst        (memrst),
        .bus           (bus),
        .outstanding_o (outstanding),
        .any_err_o     (any_err)
`ifdef EVENT_WRITEBACK_STATS_EN
        ,
        .cmd_count_o   (cmd_count),
        .err_count_o   (err_count)
`endif
    );

    initial memclk = 1'b0;
    always #5 memclk = ~memclk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, required completion of all tests");
        $fatal(1, "[TB] watchdog expired");
    end

    // Buffer k starts at k * 512 KiB; command low word is EOF + INCR + byte count.
    function automatic logic [71:0] expected_cmd(input int idx, input int tag);
        logic [31:0] addr;
        logic [31:0] ctl;
        addr = 32'(idx) * 32'd524288 + 32'h0000_3E00;
        ctl  = 32'h4080_0000 + 32'd459008;
        return {4'h0, 4'(tag), addr, ctl};
    endfunction

    function automatic logic [7:0] expected_err(input logic [7:0] sts, input int tag);
        int e;
        e = 0;
        if (sts[7] == 1'b0) e += 128;
        e += int'(sts[6:4]) * 16;
        if (int'(sts[3:0]) != tag) e += 8;
        return 8'(e);
    endfunction

    task automatic model_clear();
        mdl_flight.delete();
        mdl_tag       = 0;
        mdl_cmd_pend  = 1'b0;
        mdl_cmd       = '0;
        mdl_cmpl_pend = 1'b0;
        mdl_cmpl      = '0;
        mdl_err       = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.s_req_tvalid  = 1'b0;
        bus.s_req_tdata   = '0;
        bus.m_cmd_tready  = 1'b1;
        bus.s_sts_tvalid  = 1'b0;
        bus.s_sts_tdata   = '0;
        bus.m_cmpl_tready = 1'b1;
    endtask

    // Advance the model by one clock using the currently driven inputs, then clock the DUT.
    task automatic step();
        bit          req_ok;
        bit          sts_ok;
        logic [16:0] ent;
        logic [7:0]  err;
        req_ok = bus.s_req_tvalid && !mdl_cmd_pend && (mdl_flight.size() < MAX_OUT);
        sts_ok = bus.s_sts_tvalid && (!mdl_cmpl_pend || bus.m_cmpl_tready);
        if (mdl_cmd_pend && bus.m_cmd_tready)   mdl_cmd_pend  = 1'b0;
        if (mdl_cmpl_pend && bus.m_cmpl_tready) mdl_cmpl_pend = 1'b0;
        if (sts_ok) begin
            if (mdl_flight.size() == 0) begin
                mdl_err = 1'b1;
            end else begin
                ent           = mdl_flight.pop_front();
                err           = expected_err(bus.s_sts_tdata, int'(ent[3:0]));
                mdl_cmpl      = {3'b000, ent[16:4], err};
                mdl_cmpl_pend = 1'b1;
                if (err != 8'd0) mdl_err = 1'b1;
            end
        end
        if (req_ok) begin
            mdl_cmd      = expected_cmd(int'(bus.s_req_tdata), mdl_tag);
            mdl_cmd_pend = 1'b1;
            mdl_flight.push_back({bus.s_req_tdata, 4'(mdl_tag)});
            mdl_tag      = (mdl_tag + 1) % 16;
        end
        last_req_acc = req_ok;
        @(posedge memclk);
        @(negedge memclk);
    endtask

    task automatic apply_reset();
        idle_inputs();
        memrst = 1'b1;
        model_clear();
        repeat (2) @(negedge memclk);
        memrst = 1'b0;
        @(negedge memclk);
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.s_req_tvalid = 1'b1;
        bus.s_sts_tvalid = 1'b1;
        memrst = 1'b1;
        model_clear();
        @(negedge memclk);
        #1;
        compared++; if (bus.m_cmd_tvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_cmd_valid: got %b required 0", bus.m_cmd_tvalid); end
        compared++; if (bus.m_cmpl_tvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_cmpl_valid: got %b required 0", bus.m_cmpl_tvalid); end
        compared++; if (bus.s_req_tready !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_req_ready: got %b required 0", bus.s_req_tready); end
        compared++; if (bus.s_sts_tready !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_sts_ready: got %b required 0", bus.s_sts_tready); end
        compared++; if (outstanding !== 5'd0) begin mismatched++; $display("[TB] FAIL rst_outstanding: got %0d required 0", outstanding); end
        compared++; if (any_err !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_any_err: got %b required 0", any_err); end
        idle_inputs();
        memrst = 1'b0;
        @(negedge memclk);
        #1;
        compared++; if (bus.s_req_tready !== 1'b1) begin mismatched++; $display("[TB] FAIL post_rst_req_ready: got %b required 1", bus.s_req_tready); end
        compared++; if (bus.s_sts_tready !== 1'b1) begin mismatched++; $display("[TB] FAIL post_rst_sts_ready: got %b required 1", bus.s_sts_tready); end
    endtask

    task automatic test_single();
        apply_reset();
        bus.s_req_tdata  = 13'h0005;
        bus.s_req_tvalid = 1'b1;
        #1;
        step();
        bus.s_req_tvalid = 1'b0;
        #1;
        compared++; if (bus.m_cmd_tvalid !== 1'b1) begin mismatched++; $display("[TB] FAIL single_cmd_valid: got %b required 1", bus.m_cmd_tvalid); end
        compared++; if (bus.m_cmd_tdata !== expected_cmd(5, 0)) begin mismatched++; $display("[TB] FAIL single_cmd_data: got %h required %h", bus.m_cmd_tdata, expected_cmd(5, 0)); end
        step();
        #1;
        compared++; if (outstanding !== 5'd1) begin mismatched++; $display("[TB] FAIL single_outstanding: got %0d required 1", outstanding); end
        bus.s_sts_tdata  = 8'h80;
        bus.s_sts_tvalid = 1'b1;
        #1;
        step();
        bus.s_sts_tvalid = 1'b0;
        #1;
        compared++; if (bus.m_cmpl_tvalid !== 1'b1) begin mismatched++; $display("[TB] FAIL single_cmpl_valid: got %b required 1", bus.m_cmpl_tvalid); end
        compared++; if (bus.m_cmpl_tdata !== 24'h000500) begin mismatched++; $display("[TB] FAIL single_cmpl_data: got %h required 000500", bus.m_cmpl_tdata); end
        step();
        #1;
        compared++; if (any_err !== 1'b0) begin mismatched++; $display("[TB] FAIL single_any_err: got %b required 0", any_err); end
        compared++; if (outstanding !== 5'd0) begin mismatched++; $display("[TB] FAIL single_drained: got %0d required 0", outstanding); end
    endtask

    task automatic test_back_to_back();
        int sent;
        int cmds_seen;
        bit exp_rdy;
        apply_reset();
        sent      = 0;
        cmds_seen = 0;
        for (int c = 0; c < 20; c++) begin
            bus.s_req_tvalid = (sent < 6);
            bus.s_req_tdata  = 13'(16 + sent);
            #1;
            exp_rdy = !mdl_cmd_pend && (mdl_flight.size() < MAX_OUT);
            compared++; if (bus.s_req_tready !== exp_rdy) begin mismatched++; $display("[TB] FAIL fill_req_ready: got %b required %b", bus.s_req_tready, exp_rdy); end
            if (bus.m_cmd_tvalid && bus.m_cmd_tready) cmds_seen++;
            step();
            if (last_req_acc) sent++;
        end
        #1;
        compared++; if (outstanding !== 5'(MAX_OUT)) begin mismatched++; $display("[TB] FAIL fill_outstanding: got %0d required %0d", outstanding, MAX_OUT); end
        compared++; if (bus.s_req_tready !== 1'b0) begin mismatched++; $display("[TB] FAIL fill_blocked: got %b required 0", bus.s_req_tready); end
        compared++; if (cmds_seen !== MAX_OUT) begin mismatched++; $display("[TB] FAIL fill_cmd_count: got %0d required %0d", cmds_seen, MAX_OUT); end
        bus.s_req_tvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.s_sts_tdata  = 8'(8'h80 + k);
            bus.s_sts_tvalid = 1'b1;
            #1;
            step();
            bus.s_sts_tvalid = 1'b0;
            #1;
            compared++;
            if (bus.m_cmpl_tvalid !== 1'b1 || bus.m_cmpl_tdata !== 24'((16 + k) * 256)) begin
                mismatched++;
                $display("[TB] FAIL fill_cmpl_%0d: got valid=%b data=%h required valid=1 data=%h", k, bus.m_cmpl_tvalid, bus.m_cmpl_tdata, 24'((16 + k) * 256));
            end
        end
        step();
        #1;
        compared++; if (outstanding !== 5'd0) begin mismatched++; $display("[TB] FAIL fill_drained: got %0d required 0", outstanding); end
        for (int c = 0; c < 8; c++) begin
            bus.s_req_tvalid = (sent < 6);
            bus.s_req_tdata  = 13'(16 + sent);
            #1;
            if (mdl_cmd_pend) begin
                compared++; if (bus.m_cmd_tdata !== mdl_cmd) begin mismatched++; $display("[TB] FAIL resume_cmd_data: got %h required %h", bus.m_cmd_tdata, mdl_cmd); end
            end
            step();
            if (last_req_acc) sent++;
        end
        bus.s_req_tvalid = 1'b0;
        #1;
        compared++; if (outstanding !== 5'd2) begin mismatched++; $display("[TB] FAIL resume_outstanding: got %0d required 2", outstanding); end
    endtask

    task automatic test_error_status();
        apply_reset();
        bus.s_req_tdata  = 13'h1FFF;
        bus.s_req_tvalid = 1'b1;
        #1;
        step();
        bus.s_req_tvalid = 1'b0;
        #1;
        step();
        bus.s_sts_tdata  = 8'hC0;
        bus.s_sts_tvalid = 1'b1;
        #1;
        step();
        bus.s_sts_tvalid = 1'b0;
        #1;
        compared++; if (bus.m_cmpl_tdata !== 24'h1FFF40) begin mismatched++; $display("[TB] FAIL slverr_cmpl: got %h required 1FFF40", bus.m_cmpl_tdata); end
        compared++; if (any_err !== 1'b1) begin mismatched++; $display("[TB] FAIL slverr_any_err: got %b required 1", any_err); end
        repeat (5) step();
        #1;
        compared++; if (any_err !== 1'b1) begin mismatched++; $display("[TB] FAIL slverr_sticky: got %b required 1", any_err); end
    endtask

    task automatic test_tag_mismatch();
        apply_reset();
        bus.s_req_tdata  = 13'h00AA;
        bus.s_req_tvalid = 1'b1;
        #1;
        step();
        bus.s_req_tvalid = 1'b0;
        #1;
        step();
        bus.s_sts_tdata  = 8'h83;
        bus.s_sts_tvalid = 1'b1;
        #1;
        step();
        bus.s_sts_tvalid = 1'b0;
        #1;
        compared++; if (bus.m_cmpl_tdata !== 24'h00AA08) begin mismatched++; $display("[TB] FAIL tagmis_cmpl: got %h required 00AA08", bus.m_cmpl_tdata); end
        compared++; if (any_err !== 1'b1) begin mismatched++; $display("[TB] FAIL tagmis_any_err: got %b required 1", any_err); end
    endtask

    task automatic test_backpressure();
        logic [23:0] seen[$];
        logic [23:0] want[2];
        want[0] = 24'h010000;
        want[1] = 24'h010100;
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            bus.s_req_tdata  = 13'(13'h100 + k);
            bus.s_req_tvalid = 1'b1;
            #1;
            step();
            bus.s_req_tvalid = 1'b0;
            #1;
            step();
        end
        bus.m_cmpl_tready = 1'b0;
        bus.s_sts_tdata   = 8'h80;
        bus.s_sts_tvalid  = 1'b1;
        #1;
        step();
        bus.s_sts_tdata = 8'h81;
        #1;
        compared++; if (bus.s_sts_tready !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_sts_ready: got %b required 0", bus.s_sts_tready); end
        for (int c = 0; c < 3; c++) begin
            step();
            #1;
            compared++;
            if (bus.m_cmpl_tvalid !== 1'b1 || bus.m_cmpl_tdata !== want[0]) begin
                mismatched++;
                $display("[TB] FAIL bp_hold: got valid=%b data=%h required valid=1 data=%h", bus.m_cmpl_tvalid, bus.m_cmpl_tdata, want[0]);
            end
        end
        bus.m_cmpl_tready = 1'b1;
        #1;
        compared++; if (bus.s_sts_tready !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_release_ready: got %b required 1", bus.s_sts_tready); end
        for (int c = 0; c < 4; c++) begin
            if (bus.m_cmpl_tvalid && bus.m_cmpl_tready) seen.push_back(bus.m_cmpl_tdata);
            step();
            bus.s_sts_tvalid = 1'b0;
            #1;
        end
        compared++; if (seen.size() != 2) begin mismatched++; $display("[TB] FAIL bp_cmpl_count: got %0d required 2", seen.size()); end
        for (int i = 0; i < seen.size() && i < 2; i++) begin
            compared++; if (seen[i] !== want[i]) begin mismatched++; $display("[TB] FAIL bp_cmpl_%0d: got %h required %h", i, seen[i], want[i]); end
        end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        bus.s_req_tdata  = 13'h0020;
        bus.s_req_tvalid = 1'b1;
        #1;
        step();
        bus.s_req_tvalid = 1'b0;
        #1;
        step();
        bus.m_cmd_tready = 1'b0;
        bus.s_req_tdata  = 13'h0021;
        bus.s_req_tvalid = 1'b1;
        #1;
        step();
        bus.s_req_tvalid = 1'b0;
        #1;
        compared++; if (outstanding !== 5'd2) begin mismatched++; $display("[TB] FAIL mid_outstanding: got %0d required 2", outstanding); end
        memrst = 1'b1;
        #1;
        compared++; if (bus.m_cmd_tvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_cmd_valid: got %b required 0", bus.m_cmd_tvalid); end
        compared++; if (bus.m_cmpl_tvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_cmpl_valid: got %b required 0", bus.m_cmpl_tvalid); end
        compared++; if (bus.s_req_tready !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_req_ready: got %b required 0", bus.s_req_tready); end
        compared++; if (bus.s_sts_tready !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_sts_ready: got %b required 0", bus.s_sts_tready); end
        model_clear();
        @(negedge memclk);
        memrst           = 1'b0;
        bus.m_cmd_tready = 1'b1;
        #1;
        compared++; if (outstanding !== 5'd0) begin mismatched++; $display("[TB] FAIL mid_cleared: got %0d required 0", outstanding); end
        bus.s_sts_tdata  = 8'h80;
        bus.s_sts_tvalid = 1'b1;
        #1;
        step();
        bus.s_sts_tvalid = 1'b0;
        #1;
        compared++; if (any_err !== 1'b1) begin mismatched++; $display("[TB] FAIL stray_any_err: got %b required 1", any_err); end
        compared++; if (bus.m_cmpl_tvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL stray_no_cmpl: got %b required 0", bus.m_cmpl_tvalid); end
        bus.s_req_tdata  = 13'h0022;
        bus.s_req_tvalid = 1'b1;
        #1;
        step();
        bus.s_req_tvalid = 1'b0;
        #1;
        compared++; if (bus.m_cmd_tdata !== expected_cmd(34, 0)) begin mismatched++; $display("[TB] FAIL mid_tag_restart: got %h required %h", bus.m_cmd_tdata, expected_cmd(34, 0)); end
        step();
    endtask

    task automatic test_random_traffic();
        bit         exp_req;
        bit         exp_sts;
        logic [3:0] tag;
        logic [3:0] flags;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            bus.s_req_tvalid  = ($urandom_range(0, 2) != 0);
            bus.s_req_tdata   = 13'($urandom);
            bus.m_cmd_tready  = ($urandom_range(0, 3) != 0);
            bus.m_cmpl_tready = ($urandom_range(0, 3) != 0);
            if (mdl_flight.size() != 0) begin
                bus.s_sts_tvalid = ($urandom_range(0, 2) == 0);
                tag = mdl_flight[0][3:0];
            end else begin
                bus.s_sts_tvalid = ($urandom_range(0, 39) == 0);
                tag = 4'($urandom);
            end
            if ($urandom_range(0, 7) == 0) tag = 4'($urandom);
            flags = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b1000;
            bus.s_sts_tdata = {flags, tag};
            #1;
            exp_req = !mdl_cmd_pend && (mdl_flight.size() < MAX_OUT);
            exp_sts = !mdl_cmpl_pend || bus.m_cmpl_tready;
            compared++; if (bus.s_req_tready !== exp_req) begin mismatched++; $display("[TB] FAIL rnd_req_ready @%0d: got %b required %b", c, bus.s_req_tready, exp_req); end
            compared++; if (bus.s_sts_tready !== exp_sts) begin mismatched++; $display("[TB] FAIL rnd_sts_ready @%0d: got %b required %b", c, bus.s_sts_tready, exp_sts); end
            compared++; if (bus.m_cmd_tvalid !== mdl_cmd_pend) begin mismatched++; $display("[TB] FAIL rnd_cmd_valid @%0d: got %b required %b", c, bus.m_cmd_tvalid, mdl_cmd_pend); end
            if (mdl_cmd_pend) begin
                compared++; if (bus.m_cmd_tdata !== mdl_cmd) begin mismatched++; $display("[TB] FAIL rnd_cmd_data @%0d: got %h required %h", c, bus.m_cmd_tdata, mdl_cmd); end
            end
            compared++; if (bus.m_cmpl_tvalid !== mdl_cmpl_pend) begin mismatched++; $display("[TB] FAIL rnd_cmpl_valid @%0d: got %b required %b", c, bus.m_cmpl_tvalid, mdl_cmpl_pend); end
            if (mdl_cmpl_pend) begin
                compared++; if (bus.m_cmpl_tdata !== mdl_cmpl) begin mismatched++; $display("[TB] FAIL rnd_cmpl_data @%0d: got %h required %h", c, bus.m_cmpl_tdata, mdl_cmpl); end
            end
            compared++; if (outstanding !== 5'(mdl_flight.size())) begin mismatched++; $display("[TB] FAIL rnd_outstanding @%0d: got %0d required %0d", c, outstanding, mdl_flight.size()); end
            compared++; if (any_err !== mdl_err) begin mismatched++; $display("[TB] FAIL rnd_any_err @%0d: got %b required %b", c, any_err, mdl_err); end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_error_status();
        test_tag_mismatch();
        test_backpressure();
        test_reset_midflight();
        test_random_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
